// File: rtl/pio_key_poller_pkg.sv
// Shared types and helpers for the PIO key poller and its debouncer.
package pio_key_poller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pio_key_poller_key_debounce.sv
// Per-sample debouncer: a new level is accepted after DEBOUNCE identical samples,
// with one-cycle press (1->0) and release (0->1) pulses on each accepted change.
module pio_key_poller_key_debounce
  import pio_key_poller_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam int            CW      = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] rel_q, rel_d;

  always_comb begin
    cand_d  = cand_q;
    count_d = count_q;
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    if (update) begin
      if (sample == cand_q) begin
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
      end else begin
        cand_d  = sample;
        count_d = CW'(1);
      end
      // Commit decision uses the post-update candidate and count.
      if ((count_d == CNT_MAX) && (cand_d != state_q)) begin
        state_d = cand_d;
        press_d = state_q & ~cand_d;
        rel_d   = ~state_q & cand_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q  <= '1;
      count_q <= '0;
      state_q <= '1;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      cand_q  <= cand_d;
      count_q <= count_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

endmodule

// File: rtl/pio_key_poller.sv
// Avalon-MM initiator that polls the key PIO data register on a fixed period
// and feeds the returned bits through a debouncer.
module pio_key_poller
  import pio_key_poller_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             sample_valid
);

  localparam int            PW       = cnt_width(POLL_DIV - 1);
  localparam int            LW       = cnt_width(READ_LATENCY);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY);

  logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
  logic             tick;
  poll_state_e      state_q;
  logic             avm_read_q;
  logic [LW-1:0]    lat_q;
  logic [WIDTH-1:0] sample_q;
  logic             sample_valid_q;

  // Free-running period counter; ticks are independent of FSM state and enable.
  assign tick = (poll_cnt_q == POLL_MAX);

  always_comb begin
    poll_cnt_d = tick ? '0 : poll_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) poll_cnt_q <= '0;
    else       poll_cnt_q <= poll_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      avm_read_q     <= 1'b0;
      lat_q          <= '0;
      sample_q       <= '1;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick && enable) begin
            state_q    <= READ;
            avm_read_q <= 1'b1;
          end
        end
        READ: begin
          if (!avm_waitrequest) begin
            state_q    <= WAIT;
            avm_read_q <= 1'b0;
            lat_q      <= LW'(1);
          end
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            sample_q <= avm_readdata[WIDTH-1:0];
            state_q  <= UPDATE;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        UPDATE: begin
          sample_valid_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pio_key_poller_key_debounce #(
    .WIDTH    (WIDTH),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .update      (state_q == UPDATE),
    .sample      (sample_q),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release)
  );

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_readdata_hi;
      assign unused_readdata_hi = ^avm_readdata[31:WIDTH];
    end
  endgenerate

  assign avm_address  = PIO_DATA_ADDR;
  assign avm_read     = avm_read_q;
  assign sample_valid = sample_valid_q;

endmodule
